reg_unload_serializer: RTL and testbench

REG_UNLOAD_SERIALIZER -- requirements
Module: reg_unload_serializer

---
 rtl/reg_unload_serializer_pkg.sv | 18 +
 rtl/reg_unload_serializer_load_down_counter.sv | 37 +++
 rtl/reg_unload_serializer.sv | 100 ++++++++++
 tb/tb_reg_unload_serializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reg_unload_serializer_pkg.sv
// ----------------------------------------------------------------------------
// reg_unload_serializer_pkg
//   Shared definitions for the parallel-to-serial unload block:
//   - FSM state encoding (IDLE / SHIFT), kept as plain one-bit constants so
//     older tools and netlists see a fixed encoding.
//   - cnt_width(): bit-counter width derived from the word width.
// ----------------------------------------------------------------------------
package reg_unload_serializer_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_SHIFT = 1'b1;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/reg_unload_serializer_load_down_counter.sv
// ----------------------------------------------------------------------------
// load_down_counter
//   Loadable down counter used as the bit counter of the serializer.
//   Saturates at zero, so it can never underflow.
//
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   synchronous active-high reset (count -> 0)
//     load   in   load value into count (priority over dec)
//     value  in   CW-bit load value
//     dec    in   decrement by one when count is non-zero
//     count  out  CW-bit current count
// ----------------------------------------------------------------------------
module load_down_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] value,
    input  logic          dec,
    output logic [CW-1:0] count
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/reg_unload_serializer.sv
// ----------------------------------------------------------------------------
// reg_unload_serializer
//   Accepts a WIDTH-bit word with a ready/load handshake and unloads it one
//   bit at a time over a valid/ready serial handshake, LSB or MSB first.
//   All outputs are decoded from registered state only.
//
//   Parameters:
//     WIDTH      word width in bits (2..64)
//     MSB_FIRST  0: LSB first, 1: MSB first
//
//   Ports:
//     i_clk     in   clock, rising edge
//     i_rst     in   synchronous active-high reset
//     i_data    in   WIDTH-bit parallel word
//     i_load    in   load request, accepted when o_ready=1
//     o_ready   out  block can accept a word (IDLE)
//     o_sdata   out  current serial bit
//     o_svalid  out  o_sdata is valid (SHIFT)
//     i_sready  in   downstream accepts the current bit
//     o_last    out  current bit is the final bit of the word
//     o_busy    out  a word is held (inverse of o_ready)
// ----------------------------------------------------------------------------
module reg_unload_serializer
    import reg_unload_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_load,
    output logic             o_ready,
    output logic             o_sdata,
    output logic             o_svalid,
    input  logic             i_sready,
    output logic             o_last,
    output logic             o_busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic             state;
    logic [WIDTH-1:0] shift_word;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count;
    logic             load_acc;
    logic             xfer;

    assign load_acc = (state == STATE_IDLE)  && i_load;
    assign xfer     = (state == STATE_SHIFT) && i_sready;

    load_down_counter #(
        .CW (CW)
    ) u_bit_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (load_acc),
        .value (LAST_IDX),
        .dec   (xfer),
        .count (count)
    );

    // NOTE: combinational blocks assign a default first so no path leaves
    // the output unassigned, which would otherwise infer a latch.
    always_comb begin
        shifted = shift_word;
        if (MSB_FIRST != 0) begin
            shifted = {shift_word[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shift_word[WIDTH-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= STATE_IDLE;
            // NOTE: the data word is reset as well, so o_sdata is a known 0
            // out of reset rather than whatever the flops powered up with.
            shift_word <= '0;
        end else if (load_acc) begin
            state      <= STATE_SHIFT;
            shift_word <= i_data;
        end else if (xfer) begin
            // Shifting on the final bit too leaves the word zero in IDLE.
            shift_word <= shifted;
            if (count == '0) begin
                state <= STATE_IDLE;
            end
        end
    end

    assign o_ready  = (state == STATE_IDLE);
    assign o_busy   = (state == STATE_SHIFT);
    assign o_svalid = (state == STATE_SHIFT);
    assign o_sdata  = (MSB_FIRST != 0) ? shift_word[WIDTH-1] : shift_word[0];
    assign o_last   = (state == STATE_SHIFT) && (count == '0);

endmodule

// File: tb/tb_reg_unload_serializer.sv
// ----------------------------------------------------------------------------
// tb_reg_unload_serializer
//   Two 8-bit instances: index 0 is LSB first, index 1 is MSB first.
// ----------------------------------------------------------------------------
module tb_reg_unload_serializer;

    logic       clk = 1'b0;
    logic       rst    [2];
    logic       load   [2];
    logic [7:0] data   [2];
    logic       sready [2];
    logic       ready  [2];
    logic       sdata  [2];
    logic       svalid [2];
    logic       last   [2];
    logic       busy   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_unload_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .i_clk(clk), .i_rst(rst[0]), .i_data(data[0]), .i_load(load[0]),
        .o_ready(ready[0]), .o_sdata(sdata[0]), .o_svalid(svalid[0]),
        .i_sready(sready[0]), .o_last(last[0]), .o_busy(busy[0])
    );

    reg_unload_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .i_clk(clk), .i_rst(rst[1]), .i_data(data[1]), .i_load(load[1]),
        .o_ready(ready[1]), .o_sdata(sdata[1]), .o_svalid(svalid[1]),
        .i_sready(sready[1]), .o_last(last[1]), .o_busy(busy[1])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic r, input logic l, input logic [7:0] d, input logic sr);
        rst[s] = r; load[s] = l; data[s] = d; sready[s] = sr;
    endtask

    // Bit i of the serial stream for word d.
    function automatic logic exp_bit(input int s, input logic [7:0] d, input int i);
        return (s == 1) ? d[7-i] : d[i];
    endfunction

    // Load d, then unload it; optionally stall at bit index stall_at for
    // stall_n cycles and/or keep requesting a load of 0xFF while shifting.
    task automatic run_word(input int s, input logic [7:0] d, input int stall_at,
                            input int stall_n, input bit poke, input string tag);
        int n = 0;
        int stalled = 0;
        logic sr;
        drive(s, 1'b0, 1'b1, d, 1'b1);
        tick();
        for (int c = 0; c < 40; c++) begin
            if (!svalid[s]) break;
            check({tag, "_bit"}, sdata[s], exp_bit(s, d, n));
            check({tag, "_last"}, last[s], (n == 7));
            check({tag, "_ready"}, ready[s], 1'b0);
            sr = !((n == stall_at) && (stalled < stall_n));
            if (!sr) stalled++;
            drive(s, 1'b0, poke, poke ? 8'hFF : d, sr);
            tick();
            if (sr) n++;
        end
        check({tag, "_count"}, n, 8);
        check({tag, "_idle"}, {ready[s], svalid[s], busy[s]}, 3'b100);
        drive(s, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    typedef struct packed {
        logic       rst;
        logic       load;
        logic [7:0] data;
        logic       sready;
        logic [4:0] exp;   // {ready, valid, sdata, last, busy}
        logic       care;  // compare sdata
    } vec_t;

    vec_t tbl [12];

    // Reference model state: held word, index of the bit on the output.
    logic [7:0] m_word [2];
    int         m_idx  [2];
    bit         m_act  [2];

    initial begin
        logic [4:0] got;
        logic [4:0] mask;
        for (int s = 0; s < 2; s++) drive(s, 1'b1, 1'b0, 8'h00, 1'b0);

        // LSB-first 0xA5 walk, then load+reset in IDLE.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'b10000, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 5'b01101, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b01001, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b01101, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b01001, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b01001, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b01101, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b01001, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b01111, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b10000, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h5A, 1'b1, 5'b10000, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b10000, 1'b0};

        for (int i = 0; i < 12; i++) begin
            drive(0, tbl[i].rst, tbl[i].load, tbl[i].data, tbl[i].sready);
            tick();
            got  = {ready[0], svalid[0], sdata[0], last[0], busy[0]};
            mask = tbl[i].care ? 5'b11111 : 5'b11011;
            check($sformatf("vec%0d", i), got & mask, tbl[i].exp & mask);
        end

        // MSB-first 0x81.
        drive(1, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        check("msb_reset", {ready[1], svalid[1], sdata[1], last[1], busy[1]}, 5'b10000);
        run_word(1, 8'h81, -1, 0, 1'b0, "msb81");

        // Stall on the 2nd bit of 0xF0 for 3 cycles.
        run_word(0, 8'hF0, 1, 3, 1'b0, "stallF0");
        // Loads of 0xFF during SHIFT must be ignored.
        run_word(0, 8'h3C, -1, 0, 1'b1, "poke3C");

        // Reset after 3 transfers of 0xAA, then a fresh 0x01.
        drive(0, 1'b0, 1'b1, 8'hAA, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("aa_bit", sdata[0], exp_bit(0, 8'hAA, i));
            drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
            tick();
        end
        check("aa_pre_rst", {ready[0], svalid[0]}, 2'b01);
        drive(0, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        check("aa_rst", {ready[0], svalid[0], sdata[0], last[0], busy[0]}, 5'b10000);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        check("aa_stay_idle", {ready[0], svalid[0]}, 2'b10);
        run_word(0, 8'h01, -1, 0, 1'b0, "after_rst01");

        // Randomized run on both instances against the model.
        for (int s = 0; s < 2; s++) begin
            drive(s, 1'b1, 1'b0, 8'h00, 1'b0);
            m_act[s] = 1'b0; m_idx[s] = 0; m_word[s] = 8'h00;
        end
        tick();
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < 2; s++) begin
                drive(s, ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                      8'($urandom), ($urandom_range(0, 2) != 0));
            end
            @(posedge clk);
            for (int s = 0; s < 2; s++) begin
                if (rst[s]) begin
                    m_act[s] = 1'b0;
                end else if (!m_act[s] && load[s]) begin
                    m_act[s] = 1'b1; m_word[s] = data[s]; m_idx[s] = 0;
                end else if (m_act[s] && sready[s]) begin
                    if (m_idx[s] == 7) m_act[s] = 1'b0;
                    else m_idx[s]++;
                end
            end
            #1;
            for (int s = 0; s < 2; s++) begin
                check($sformatf("rnd%0d_ctl", s), {ready[s], svalid[s], last[s], busy[s]},
                      {!m_act[s], m_act[s], m_act[s] && (m_idx[s] == 7), m_act[s]});
                if (m_act[s])
                    check($sformatf("rnd%0d_bit", s), sdata[s], exp_bit(s, m_word[s], m_idx[s]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
